// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Field-bundle handshake and instruction-memory write bus for instr_encoder.
//   master : field source (drives the bundle, observes the memory-side outputs)
//   slave  : the encoder itself
//
//   in_valid/in_ready : bundle handshake, accept when both are high
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last : decoded fields
//   mem_we/mem_addr/mem_wdata : one-cycle write strobe, byte address, word
//   count : words written so far
//   done  : program complete (sticky)
//   err   : illegal format / misaligned B-J immediate / overflow (sticky)
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            fmt;
   logic [6:0]            opcode;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [31:0]           imm;
   logic                  last;
   logic                  mem_we;
   logic [ADDR_WIDTH+1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [ADDR_WIDTH:0]   count;
   logic                  done;
   logic                  err;

   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err
   );

   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last,
      output in_ready, mem_we, mem_addr, mem_wdata, count, done, err
   );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Sequential RV32I encoder / program loader. Each accepted field bundle is
//   packed into a 32-bit instruction word and written, one cycle later, to the
//   next consecutive instruction-memory word starting at byte address 0.
//   Loading ends on a bundle flagged last or when the memory is full; after
//   that the encoder stays in DONE until reset.
//
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : instr_encoder_if.slave (handshake, fields, memory write bus, status)
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   instr_encoder_if.slave bus
);
   localparam int          DEPTH = 1 << ADDR_WIDTH;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic [2:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_J = 3'b011,
      FMT_U = 3'b100,
      FMT_R = 3'b101
   } fmt_e;

   typedef enum logic {
      S_LOAD,
      S_DONE
   } state_e;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [ADDR_WIDTH:0]   r_wptr;
   logic                  r_we;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_err;

   logic                  w_ready;
   logic                  w_accept;
   logic [ADDR_WIDTH:0]   w_wptr_nxt;
   logic                  w_full;
   logic                  w_is_shift;
   logic [31:0]           w_word;
   logic                  w_word_err;

   assign w_ready    = (r_state == S_LOAD) && !rst;
   assign w_accept   = bus.in_valid && w_ready;
   assign w_wptr_nxt = r_wptr + (ADDR_WIDTH+1)'(1);
   assign w_full     = (w_wptr_nxt == (ADDR_WIDTH+1)'(DEPTH));

   // Shift-immediate forms carry funct7 in the upper bits and a 5-bit shamt.
   assign w_is_shift = (bus.opcode == 7'b0010011) &&
                       ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101));

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_word     = NOP;
      w_word_err = 1'b0;
      case (fmt_e'(bus.fmt))
         FMT_R: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         FMT_I: begin
            if (w_is_shift)
               w_word = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            else
               w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         FMT_S: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
         FMT_B: begin
            w_word     = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11], bus.opcode};
            w_word_err = bus.imm[0];
         end
         FMT_U: w_word = {bus.imm[31:12], bus.rd, bus.opcode};
         FMT_J: begin
            w_word     = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                          bus.rd, bus.opcode};
            w_word_err = bus.imm[0];
         end
         default: w_word_err = 1'b1;   // illegal format: slot filled with nop
      endcase
   end

   // Next-state logic: finish on the last bundle or when memory fills up.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD: if (w_accept && (bus.last || w_full)) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_DONE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_LOAD;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_we <= w_accept;
         if (w_accept) begin
            // Address and data hold their last values while idle.
            r_addr  <= {r_wptr[ADDR_WIDTH-1:0], 2'b00};
            r_wdata <= w_word;
            r_wptr  <= w_wptr_nxt;
            r_err   <= r_err | w_word_err | (w_full & ~bus.last);
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.count     = r_wptr;
   assign bus.done      = (r_state == S_DONE);
   assign bus.err       = r_err;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: the inverse of the control unit's decode path. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit RV32I words. It writes each word to consecutive instruction-memory locations starting at byte address 0. It sits beside the instruction memory and is used to load self-generated programs before the CPU is released from reset.

## Interface
- ADDR_WIDTH, 8, word-address width; capacity DEPTH = 2^ADDR_WIDTH words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- fmt  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110/111 illegal
- opcode  in  7  instr[6:0]
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25] (R, and I-shift)
- imm  in  32  immediate, unshifted byte value (U: full 32-bit value, low 12 bits ignored)
- last  in  1  bundle is the final instruction of the program
- mem_we  out  1  write strobe, one cycle per encoded word
- mem_addr  out  ADDR_WIDTH+2  byte address, low 2 bits always 0
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_WIDTH+1  words written so far
- done  out  1  program complete; sticky until rst
- err  out  1  sticky illegal-format / misaligned-immediate flag

## Operation
- States: LOAD, DONE. Reset enters LOAD.
- Accept occurs when in_valid && in_ready. in_ready = (state == LOAD) && !rst.
- Encoding on accept:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}. If opcode == 0010011 and funct3 is 001 or 101, bits [31:25] = funct7 and [24:20] = imm[4:0].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegal fmt: write 32'h00000013 (nop) in that slot and set err.
- B or J with imm[0] = 1: encode normally (bit 0 dropped) and set err.
- Write pointer wptr (ADDR_WIDTH+1 bits) increments on every accept. mem_addr = {wptr[ADDR_WIDTH-1:0], 2'b00} of the slot being written. count = wptr.
- LOAD → DONE on an accept with last = 1, or on the accept that makes wptr == DEPTH (memory full). In the full case without last, err is also set.
- DONE: in_ready = 0, no further writes. The only exit is rst.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, count 0, done 0, err 0, state LOAD, wptr 0. in_ready is 0 during any cycle with rst high.
- Latency 1: a bundle accepted at edge N drives mem_we = 1, mem_addr and mem_wdata registered at edge N, valid for cycle N+1.
- Throughput 1 word per cycle. Back-to-back accepts produce continuous mem_we.
- mem_we is low in any cycle not following an accept. mem_addr/mem_wdata hold their last values when idle.
- count and done update at the same edge as the final write's registers. done = 1 in the same cycle mem_we = 1 for the last word. in_ready drops in that cycle.
- err asserts in the same cycle as the offending word's mem_we.
- No wrap-around: the pointer never returns to 0 except by rst.
- rst mid-stream: at the next edge all state clears and the in-flight write is dropped (mem_we = 0). Memory contents are not cleared.
- in_valid with in_ready low: bundle ignored. The source must hold it until accepted.

## Test plan
- Stream addi x1,x0,5 (I, 0010011, rd1, imm 5); sw x2,8(x1) (S, 0100011, f3 010); add x3,x1,x2 (R, 0110011) with last. Expect 0x00500093@0x0, 0x0020A423@0x4, 0x002081B3@0x8 on three consecutive mem_we cycles, done = 1 with the third, count = 3.
- beq x1,x2,-8 (B, 1100011, imm 0xFFFFFFF8) → 0xFE208CE3; jal x1,16 (J, 1101111) → 0x010000EF; lui x5,0x12345 (U, imm 0x12345000) → 0x123452B7; srai x1,x1,3 (I, f3 101, funct7 0100000, imm 3) → 0x4030D093.
- Gapped in_valid (one bundle every 3 cycles) → exactly one mem_we per accept, addresses 0x0, 0x4, 0x8 with no skips.
- ADDR_WIDTH = 2, send 5 bundles without last → 4 writes (0x0–0xC), done and err set after the 4th, 5th bundle never accepted (in_ready = 0).
- fmt = 111 → nop 0x00000013 written and err = 1. B with imm = 5 → err = 1, word still written.
- Assert rst for one cycle after 2 accepts of a 4-instruction stream → count = 0, done = 0, err = 0, next accept writes to 0x0.
